// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
//   Shared pipeline definitions for the memory-access stage and its ME/WB
//   register: FSM state encoding, the bubble instruction word and the
//   register-index width.
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int          REG_W     = 5;
  localparam logic [31:0] NOP_INSTR = 32'h00000020;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stage_me_wb.sv
// ---------------------------------------------------------------------------
// mem_stage_me_wb
//   ME/WB pipeline register. When bubble is high the slot is replaced by a
//   harmless NOP (no register write, zeroed payload).
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   bubble          insert a NOP instead of the incoming slot
//   result, td      writeback data and destination register
//   wreg            writeback enable
//   instr           instruction word carried for debug
//   wb_*            registered outputs towards writeback
// ---------------------------------------------------------------------------
module mem_stage_me_wb #(
  parameter logic [31:0] NOP_INSTR = mem_stage_pkg::NOP_INSTR
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bubble,
  input  logic [31:0]                    result,
  input  logic [mem_stage_pkg::REG_W-1:0] td,
  input  logic                           wreg,
  input  logic [31:0]                    instr,
  output logic [31:0]                    wb_result,
  output logic [mem_stage_pkg::REG_W-1:0] wb_td,
  output logic                           wb_WREG,
  output logic [31:0]                    wb_instr
);
  import mem_stage_pkg::*;

  // ME -> WB boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_result <= '0;
      wb_td     <= '0;
      wb_WREG   <= 1'b0;
      wb_instr  <= NOP_INSTR;
    end else if (bubble) begin
      wb_result <= '0;
      wb_td     <= '0;
      wb_WREG   <= 1'b0;
      wb_instr  <= NOP_INSTR;
    end else begin
      wb_result <= result;
      wb_td     <= td;
      wb_WREG   <= wreg;
      wb_instr  <= instr;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of the 5-stage pipeline. Issues loads/stores over a
//   req/ack data-memory port with variable latency, stalls upstream while an
//   access is outstanding, aborts after TIMEOUT wait cycles and feeds the
//   ME/WB register.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   me_aluresult, me_d2      address / ALU result and store data from EX/ME
//   me_td, me_WREG           destination register and write enable
//   me_WMEM, me_LW           store / load (LW wins when both set)
//   me_instr                 instruction word (debug)
//   dmem_req/we/addr/wdata   data-memory request side
//   dmem_ack, dmem_rdata     data-memory completion pulse and load data
//   mem_stall                freezes PC/IF/ID/EX and the EX/ME register
//   mem_err                  sticky: misaligned access or timeout
//   wb_result/td/WREG/instr  ME/WB register outputs
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int          ADDR_W    = 10,
  parameter int          TIMEOUT   = 15,
  parameter logic [31:0] NOP_INSTR = mem_stage_pkg::NOP_INSTR
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     me_aluresult,
  input  logic [31:0]                     me_d2,
  input  logic [mem_stage_pkg::REG_W-1:0] me_td,
  input  logic                            me_WREG,
  input  logic                            me_WMEM,
  input  logic                            me_LW,
  input  logic [31:0]                     me_instr,
  output logic                            dmem_req,
  output logic                            dmem_we,
  output logic [ADDR_W-1:0]               dmem_addr,
  output logic [31:0]                     dmem_wdata,
  input  logic                            dmem_ack,
  input  logic [31:0]                     dmem_rdata,
  output logic                            mem_stall,
  output logic                            mem_err,
  output logic [31:0]                     wb_result,
  output logic [mem_stage_pkg::REG_W-1:0] wb_td,
  output logic                            wb_WREG,
  output logic [31:0]                     wb_instr
);
  import mem_stage_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    wait_cnt;
  logic [DATA_W-1:0]   cap_data;
  logic                aborted;

  logic                mem_op;
  logic                misaligned;
  logic                timeout_hit;

  logic                bubble;
  logic [DATA_W-1:0]   wb_result_d;
  logic                wb_wreg_d;

  assign mem_op      = me_LW | me_WMEM;
  assign misaligned  = (me_aluresult[1:0] != 2'b00);
  assign timeout_hit = (state == WAIT) && !dmem_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Address and write data are passed straight through; upstream is frozen
  // during WAIT so they stay stable for the whole access.
  assign dmem_addr  = me_aluresult[ADDR_W+1:2];
  assign dmem_wdata = me_d2;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_op && !misaligned) state_nxt = WAIT;
      WAIT:    if (dmem_ack || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs. dmem_req is decoded from state, so an asynchronous reset
  // drops it in the same cycle.
  always_comb begin
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    mem_stall   = 1'b0;
    bubble      = 1'b0;
    wb_result_d = me_aluresult;
    wb_wreg_d   = me_WREG;
    case (state)
      IDLE: begin
        if (mem_op) begin
          bubble    = 1'b1;
          mem_stall = !misaligned;
        end
      end
      WAIT: begin
        dmem_req  = 1'b1;
        dmem_we   = me_WMEM & ~me_LW;
        mem_stall = 1'b1;
        bubble    = 1'b1;
      end
      DONE: begin
        wb_result_d = me_LW ? cap_data : me_aluresult;
        wb_wreg_d   = me_WREG & ~aborted;
      end
      default: ;
    endcase
  end

  // Access bookkeeping: wait counter, captured load data, abort and error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      cap_data <= '0;
      aborted  <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && misaligned) begin
            mem_err <= 1'b1;
          end else if (mem_op) begin
            wait_cnt <= '0;
            aborted  <= 1'b0;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            cap_data <= dmem_rdata;
          end else if (timeout_hit) begin
            mem_err  <= 1'b1;
            cap_data <= '0;
            aborted  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  mem_stage_me_wb #(
    .NOP_INSTR (NOP_INSTR)
  ) u_me_wb (
    .clk       (clk),
    .rst       (rst),
    .bubble    (bubble),
    .result    (wb_result_d),
    .td        (me_td),
    .wreg      (wb_wreg_d),
    .instr     (me_instr),
    .wb_result (wb_result),
    .wb_td     (wb_td),
    .wb_WREG   (wb_WREG),
    .wb_instr  (wb_instr)
  );

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//   Directed-vector bench for mem_stage: non-memory pass-through, load with
//   delayed ack, store with same-cycle ack, misaligned access, timeout and
//   reset during an outstanding access.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam int          ADDR_W = 10;
  localparam int          TMO    = 15;
  localparam logic [31:0] NOP    = 32'h00000020;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       me_aluresult;
  logic [31:0]       me_d2;
  logic [4:0]        me_td;
  logic              me_WREG;
  logic              me_WMEM;
  logic              me_LW;
  logic [31:0]       me_instr;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;
  logic              mem_stall;
  logic              mem_err;
  logic [31:0]       wb_result;
  logic [4:0]        wb_td;
  logic              wb_WREG;
  logic [31:0]       wb_instr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(
    .ADDR_W    (ADDR_W),
    .TIMEOUT   (TMO),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .me_aluresult (me_aluresult),
    .me_d2        (me_d2),
    .me_td        (me_td),
    .me_WREG      (me_WREG),
    .me_WMEM      (me_WMEM),
    .me_LW        (me_LW),
    .me_instr     (me_instr),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .mem_stall    (mem_stall),
    .mem_err      (mem_err),
    .wb_result    (wb_result),
    .wb_td        (wb_td),
    .wb_WREG      (wb_WREG),
    .wb_instr     (wb_instr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [31:0] d2,
                        input logic [4:0] td, input logic wreg,
                        input logic wmem, input logic lw,
                        input logic [31:0] instr);
    me_aluresult = alu;
    me_d2        = d2;
    me_td        = td;
    me_WREG      = wreg;
    me_WMEM      = wmem;
    me_LW        = lw;
    me_instr     = instr;
  endtask

  task automatic set_idle();
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, NOP);
  endtask

  // Called mid-cycle in the IDLE cycle of an aligned memory op. Walks the
  // WAIT cycles, pulses ack on WAIT cycle index ack_at (-1: never) and
  // returns once the stage is in DONE.
  task automatic mem_access(input int ack_at, input logic [31:0] rd,
                            output int n_stall, output int n_req,
                            output logic we0, output logic bub_ok);
    int   widx;
    logic done;
    n_stall = mem_stall ? 1 : 0;
    n_req   = 0;
    we0     = 1'b0;
    bub_ok  = 1'b1;
    widx    = 0;
    done    = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      dmem_ack = 1'b0;
      if (!dmem_req) begin
        done = 1'b1;
      end else begin
        n_req++;
        if (mem_stall) n_stall++;
        if (widx == 0) we0 = dmem_we;
        if (wb_WREG !== 1'b0 || wb_instr !== NOP) bub_ok = 1'b0;
        if (widx == ack_at) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rd;
        end
        widx++;
      end
    end
    check_eq("access_completes", {31'b0, done}, 32'd1);
  endtask

  int   ns, nr;
  logic we0, bok;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    set_idle();

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_wb_result", wb_result, 32'h0);
    check_eq("rst_wb_td",     {27'b0, wb_td}, 32'h0);
    check_eq("rst_wb_WREG",   {31'b0, wb_WREG}, 32'h0);
    check_eq("rst_wb_instr",  wb_instr, NOP);
    check_eq("rst_mem_err",   {31'b0, mem_err}, 32'h0);
    check_eq("rst_dmem_req",  {31'b0, dmem_req}, 32'h0);
    rst = 1'b0;

    // non-memory op: one-cycle pass-through
    step();
    set_op(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h11111111);
    #1;
    check_eq("alu_stall", {31'b0, mem_stall}, 32'h0);
    check_eq("alu_req",   {31'b0, dmem_req}, 32'h0);
    step();
    set_idle();
    check_eq("alu_wb_result", wb_result, 32'h1234);
    check_eq("alu_wb_td",     {27'b0, wb_td}, 32'd5);
    check_eq("alu_wb_WREG",   {31'b0, wb_WREG}, 32'd1);
    check_eq("alu_wb_instr",  wb_instr, 32'h11111111);

    // load, ack on the third WAIT cycle
    set_op(32'h40, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 32'h8C070040);
    #1;
    check_eq("ld_addr",       {22'b0, dmem_addr}, 32'h010);
    check_eq("ld_idle_stall", {31'b0, mem_stall}, 32'd1);
    mem_access(2, 32'hCAFEF00D, ns, nr, we0, bok);
    check_eq("ld_stall_cycles", ns, 32'd4);
    check_eq("ld_req_cycles",   nr, 32'd3);
    check_eq("ld_we",           {31'b0, we0}, 32'd0);
    check_eq("ld_bubbles",      {31'b0, bok}, 32'd1);
    check_eq("ld_done_stall",   {31'b0, mem_stall}, 32'd0);
    check_eq("ld_done_req",     {31'b0, dmem_req}, 32'd0);
    step();
    set_idle();
    check_eq("ld_wb_result", wb_result, 32'hCAFEF00D);
    check_eq("ld_wb_td",     {27'b0, wb_td}, 32'd7);
    check_eq("ld_wb_WREG",   {31'b0, wb_WREG}, 32'd1);
    check_eq("ld_wb_instr",  wb_instr, 32'h8C070040);

    // store, same-cycle ack
    set_op(32'h8, 32'hAA55, 5'd0, 1'b0, 1'b1, 1'b0, 32'hAC000008);
    #1;
    check_eq("st_addr",  {22'b0, dmem_addr}, 32'h002);
    check_eq("st_wdata", dmem_wdata, 32'hAA55);
    mem_access(0, 32'hDEADBEEF, ns, nr, we0, bok);
    check_eq("st_stall_cycles", ns, 32'd2);
    check_eq("st_req_cycles",   nr, 32'd1);
    check_eq("st_we",           {31'b0, we0}, 32'd1);
    step();
    set_idle();
    check_eq("st_wb_WREG",  {31'b0, wb_WREG}, 32'd0);
    check_eq("st_wb_result", wb_result, 32'h8);
    check_eq("st_mem_err",  {31'b0, mem_err}, 32'd0);

    // misaligned load: no access, bubble, sticky error
    set_op(32'h41, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 32'h8C060041);
    #1;
    check_eq("mis_stall", {31'b0, mem_stall}, 32'd0);
    check_eq("mis_req",   {31'b0, dmem_req}, 32'd0);
    step();
    check_eq("mis_req_after", {31'b0, dmem_req}, 32'd0);
    set_idle();
    check_eq("mis_err",      {31'b0, mem_err}, 32'd1);
    check_eq("mis_wb_WREG",  {31'b0, wb_WREG}, 32'd0);
    check_eq("mis_wb_instr", wb_instr, NOP);

    // only reset clears the error flag
    step();
    check_eq("err_sticky", {31'b0, mem_err}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("err_cleared", {31'b0, mem_err}, 32'd0);

    // no ack: abort after TIMEOUT wait cycles
    step();
    set_op(32'h80, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 32'h8C090080);
    #1;
    mem_access(-1, 32'h0, ns, nr, we0, bok);
    check_eq("tmo_req_cycles",   nr, TMO);
    check_eq("tmo_stall_cycles", ns, TMO + 1);
    check_eq("tmo_err",          {31'b0, mem_err}, 32'd1);
    check_eq("tmo_done_stall",   {31'b0, mem_stall}, 32'd0);
    step();
    set_op(32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h22222222);
    check_eq("tmo_wb_WREG",  {31'b0, wb_WREG}, 32'd0);
    check_eq("tmo_wb_result", wb_result, 32'h0);
    check_eq("tmo_wb_td",    {27'b0, wb_td}, 32'd9);
    #1;
    check_eq("next_stall", {31'b0, mem_stall}, 32'd0);
    step();
    set_idle();
    check_eq("next_wb_result", wb_result, 32'h55);
    check_eq("next_wb_WREG",   {31'b0, wb_WREG}, 32'd1);
    check_eq("next_wb_td",     {27'b0, wb_td}, 32'd3);

    // reset while waiting for ack
    set_op(32'h100, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 32'h8C040100);
    step();
    check_eq("rw_req_before", {31'b0, dmem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rw_req",       {31'b0, dmem_req}, 32'd0);
    check_eq("rw_wb_result", wb_result, 32'h0);
    check_eq("rw_wb_td",     {27'b0, wb_td}, 32'h0);
    check_eq("rw_wb_WREG",   {31'b0, wb_WREG}, 32'h0);
    check_eq("rw_wb_instr",  wb_instr, NOP);
    check_eq("rw_mem_err",   {31'b0, mem_err}, 32'h0);
    @(negedge clk);
    set_idle();
    rst = 1'b0;
    step();
    check_eq("rw_idle_req", {31'b0, dmem_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline, placed directly downstream of the EX/ME pipeline register.
- Consumes the EX/ME outputs: ALU result, store data, destination register, WREG/WMEM/LW control and instruction word.
- Performs loads and stores through a req/ack data-memory port with variable latency, and stalls the upstream pipeline while an access is outstanding.
- Contains the ME/WB pipeline register that feeds writeback.

Parameters:
- ADDR_W, 10, word-address width of dmem_addr.
- TIMEOUT, 15, maximum WAIT cycles without dmem_ack before the access is aborted.
- NOP_INSTR, 32'h00000020, instruction word used for reset and bubble slots.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- me_aluresult  in  32  effective address or ALU result.
- me_d2  in  32  store data.
- me_td  in  5  destination register.
- me_WREG  in  1  instruction writes the register file.
- me_WMEM  in  1  store.
- me_LW  in  1  load.
- me_instr  in  32  instruction word, carried for debug.
- dmem_req  out  1  memory request, held until ack or timeout.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  word address = me_aluresult[ADDR_W+1:2].
- dmem_wdata  out  32  = me_d2.
- dmem_ack  in  1  one-cycle completion pulse.
- dmem_rdata  in  32  load data, valid when dmem_ack=1.
- mem_stall  out  1  freeze PC/IF/ID/EX and the EX/ME register.
- mem_err  out  1  sticky error flag (misaligned address or timeout).
- wb_result  out  32  writeback data.
- wb_td  out  5  writeback destination.
- wb_WREG  out  1  writeback enable.
- wb_instr  out  32  instruction word in the WB stage.

Behaviour:
- Memory-op definition: an instruction is a memory op when me_LW or me_WMEM is 1. If both are 1, LW wins and WMEM is ignored.
- FSM states are IDLE, WAIT and DONE. The FSM and all registers are reset asynchronously.
- Reset values: state=IDLE, wait counter=0, captured data=0, mem_err=0, wb_result=0, wb_td=0, wb_WREG=0, wb_instr=NOP_INSTR.
- Reset mid-operation: asserting rst while in WAIT drops dmem_req immediately (it is decoded from state) and returns the FSM to IDLE.
- IDLE, no memory op:
  - mem_stall=0.
  - ME/WB latches aluresult, td, WREG and instr on the next edge. Non-memory latency is 1 cycle.
- IDLE, memory op with me_aluresult[1:0]!=0 (misaligned):
  - No access is issued and mem_stall=0.
  - ME/WB latches a bubble: wb_WREG=0, wb_instr=NOP_INSTR.
  - mem_err is set.
- IDLE, aligned memory op:
  - mem_stall=1, next state WAIT, wait counter cleared.
- WAIT:
  - dmem_req=1, dmem_we=me_WMEM & ~me_LW. dmem_addr/dmem_wdata follow the inputs, which are stable because upstream is stalled.
  - mem_stall=1; ME/WB latches a bubble every cycle.
  - On dmem_ack=1: capture dmem_rdata, next state DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without ack: set mem_err, capture 0, mark the slot as aborted, next state DONE.
- DONE:
  - mem_stall=0, dmem_req=0.
  - ME/WB latches wb_result = captured data if LW, else aluresult; wb_td=me_td; wb_instr=me_instr.
  - wb_WREG = me_WREG & ~aborted.
  - Next state IDLE. Minimum memory-op latency is therefore 3 cycles (IDLE -> WAIT with same-cycle ack -> DONE).
- dmem_ack outside WAIT is ignored.
- mem_err is cleared only by rst.
- Store: wb_WREG=me_WREG, which the decoder drives to 0 for stores.

Decomposition:
- Shared pipeline package holds:
  - the FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2),
  - NOP_INSTR,
  - the register-index width (5).
- Natural sub-module: me_wb, the ME/WB register with a bubble-insert input. It is reusable by a later pipeline revision.

Test Plan:
- Non-memory op: aluresult=0x1234, td=5, WREG=1 -> next edge wb_result=0x1234, wb_td=5, wb_WREG=1; mem_stall never 1.
- Load with ack 2 cycles after dmem_req rises, rdata=0xCAFEF00D, aluresult=0x40:
  - dmem_addr=0x010, dmem_we=0.
  - mem_stall=1 for 4 cycles (IDLE detect + 3 WAIT cycles); WB gets bubbles (wb_instr=0x20) meanwhile.
  - Then wb_result=0xCAFEF00D, wb_WREG=1.
- Store aluresult=0x8, d2=0xAA55 with same-cycle ack -> dmem_we=1, dmem_wdata=0xAA55, dmem_addr=0x002; mem_stall high exactly 2 cycles.
- Misaligned load, aluresult=0x41 -> dmem_req stays 0, mem_err=1, wb_WREG=0, mem_stall=0.
- No ack -> dmem_req high for exactly 15 cycles, then mem_err=1, wb_WREG=0; the following instruction proceeds normally.
- Assert rst during WAIT -> dmem_req=0 in the same cycle, all outputs at reset values, wb_instr=0x00000020.
